gauss3x3_window: RTL and testbench
==================================

# gauss3x3_window

Consumer end of the line-buffer chain in the 3x3 Gaussian FIR filter. Takes the three vertically aligned pixel taps produced by the two cascaded line buffers plus the live pixel, forms a 3x3 sliding window, and applies the 1-2-1 / 2-4-2 / 1-2-1 kernel with divide-by-16 rounding. Produces one filtered pixel per valid window, with line and frame end markers. Uses a valid-only border policy: no padding, so the output image is (IMG_WIDTH-2) x (IMG_HEIGHT-2).

## Interface
- WIDTH, 8, pixel bit width
- IMG_WIDTH, 4, input pixels per line (≥3)
- IMG_HEIGHT, 4, input lines per frame (≥3)

- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tap_top  in  WIDTH  pixel from line y-2 (second line buffer dout)
- tap_mid  in  WIDTH  pixel from line y-1 (first line buffer dout)
- tap_bot  in  WIDTH  live pixel, line y
- taps_valid  in  1  all three taps valid this cycle (first-buffer out_en chain)
- dout  out  WIDTH  filtered pixel; 0 when valid_out low
- valid_out  out  1  dout valid, one-cycle strobe per output pixel
- line_end  out  1  coincides with valid_out on last pixel of an output line
- frame_end  out  1  coincides with valid_out on last pixel of the output frame

## Operation
- Window: three 3-deep shift registers, one per row. Each shifts in its tap only on taps_valid, so column 2 holds the newest pixel. No shift when taps_valid is low; contents hold.
- col_cnt, range 0..IMG_WIDTH-1:
  - increments on taps_valid
  - at IMG_WIDTH-1 with taps_valid, wraps to 0 and increments row_cnt
- row_cnt, range 0..IMG_HEIGHT-3, counts output lines. It wraps to 0 after the last line, ready for the next frame.
- Window qualify: taps_valid && col_cnt ≥ 2, where col_cnt is the value before the increment. Columns 0 and 1 of every line produce no output, so stale pixels from the previous line are never used.
- Arithmetic:
  - Stage 1, per row: h = a + 2b + c, width WIDTH+2.
  - Stage 2: s = h_top + 2·h_mid + h_bot, width WIDTH+4.
  - Stage 3: dout = (s + 8) >> 4, truncated to WIDTH.
  - The maximum s is 16·(2^WIDTH−1); (s+8)>>4 equals 2^WIDTH−1 at that value, so no saturation logic is needed.
- Pipeline is 3 register stages and runs every cycle, never stalled. The qualify flag, line-end flag (col_cnt==IMG_WIDTH-1) and frame-end flag (additionally row_cnt==IMG_HEIGHT-3) travel alongside the data.
- dout is forced to 0 in any cycle where valid_out is low.
- No backpressure. A downstream consumer must accept one pixel per cycle.

## Timing
- Reset, applied next edge and at any point including mid-line:
  - dout=0, valid_out=0, line_end=0, frame_end=0
  - window registers 0, col_cnt=0, row_cnt=0, all pipeline valids 0
  - any in-flight pixels are discarded
- Latency: taps_valid high in cycle n with a qualifying column gives valid_out high in cycle n+3, carrying that window's result.
- Back-to-back taps_valid yields back-to-back valid_out. Gaps in taps_valid reproduce as identical gaps 3 cycles later.
- Per input line with IMG_WIDTH taps_valid cycles:
  - exactly IMG_WIDTH-2 valid_out pulses
  - line_end on the last of them
- Per frame: (IMG_HEIGHT-2) line_end pulses. frame_end is asserted together with the final line_end.
- taps_valid in the cycle col_cnt wraps: counters update on the same edge. The next taps_valid is treated as column 0 of the next line.
- taps_valid asserted while rst is high: ignored.

## Test plan
- Flat image, all taps 100, WIDTH=8, 4x4 → 4 outputs total, each dout=100. valid_out in cycles n+3 for the qualifying inputs; line_end on outputs 2 and 4; frame_end on output 4.
- Impulse: centre pixel of a 3x3 region = 16, rest 0 → centre output 4. A neighbouring output whose window sees 16 only at an edge weight (2) gives (32+8)>>4 = 2.
- Rounding and extremes:
  - window all 0 except one corner = 8 → dout 1 ((8+8)>>4)
  - corner = 7 → dout 0
  - all 255 → dout 255
- Gapped input: taps_valid toggled 1-0-1-0 across a line → valid_out pattern identical, delayed 3 cycles; values match the gap-free run.
- Multi-frame: two consecutive 6x5 frames → 4 outputs per line, 3 line_end and 1 frame_end per frame; second frame outputs are unaffected by the first.
- Reset mid-line: assert rst after column 2 of row 1 → all outputs 0 from the next cycle. The next frame restarts at col 0 / row 0 with correct counts.

Source files
------------

// File: rtl/gauss3x3_window.sv
// 3x3 Gaussian window and kernel (1-2-1 / 2-4-2 / 1-2-1, /16 with rounding) fed by
// line-buffer taps. Valid-only border: columns 0 and 1 of each line produce no output.
module gauss3x3_window #(
   parameter int WIDTH      = 8,
   parameter int IMG_WIDTH  = 4,
   parameter int IMG_HEIGHT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] tap_top,
   input  logic [WIDTH-1:0] tap_mid,
   input  logic [WIDTH-1:0] tap_bot,
   input  logic             taps_valid,
   output logic [WIDTH-1:0] dout,
   output logic             valid_out,
   output logic             line_end,
   output logic             frame_end
);

   localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int RW = (IMG_HEIGHT - 2 > 1) ? $clog2(IMG_HEIGHT - 2) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 3);

   // Window rows: index 2 is the newest column.
   logic [2:0][WIDTH-1:0] top_q, top_d;
   logic [2:0][WIDTH-1:0] mid_q, mid_d;
   logic [2:0][WIDTH-1:0] bot_q, bot_d;

   logic [CW-1:0] col_cnt_q, col_cnt_d;
   logic [RW-1:0] row_cnt_q, row_cnt_d;

   logic v1_q, v1_d, le1_q, le1_d, fe1_q, fe1_d;
   logic [WIDTH+3:0] s_q, s_d;
   logic v2_q, v2_d, le2_q, le2_d, fe2_q, fe2_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic valid_out_q, valid_out_d, line_end_q, line_end_d, frame_end_q, frame_end_d;

   logic [WIDTH+1:0] h_top, h_mid, h_bot;

   always_comb begin
      top_d = top_q;
      mid_d = mid_q;
      bot_d = bot_q;
      col_cnt_d = col_cnt_q;
      row_cnt_d = row_cnt_q;
      if (taps_valid) begin
         top_d = {tap_top, top_q[2], top_q[1]};
         mid_d = {tap_mid, mid_q[2], mid_q[1]};
         bot_d = {tap_bot, bot_q[2], bot_q[1]};
         if (col_cnt_q == COL_LAST) begin
            col_cnt_d = '0;
            row_cnt_d = (row_cnt_q == ROW_LAST) ? '0 : row_cnt_q + RW'(1);
         end else begin
            col_cnt_d = col_cnt_q + CW'(1);
         end
      end

      // Flags use the column count before this cycle's increment.
      v1_d  = taps_valid && (col_cnt_q >= CW'(2));
      le1_d = taps_valid && (col_cnt_q == COL_LAST);
      fe1_d = le1_d && (row_cnt_q == ROW_LAST);

      h_top = {2'b00, top_q[0]} + {1'b0, top_q[1], 1'b0} + {2'b00, top_q[2]};
      h_mid = {2'b00, mid_q[0]} + {1'b0, mid_q[1], 1'b0} + {2'b00, mid_q[2]};
      h_bot = {2'b00, bot_q[0]} + {1'b0, bot_q[1], 1'b0} + {2'b00, bot_q[2]};
      s_d   = {2'b00, h_top} + {1'b0, h_mid, 1'b0} + {2'b00, h_bot};
      v2_d  = v1_q;
      le2_d = le1_q;
      fe2_d = fe1_q;

      // Max s is 16*(2^WIDTH-1), so s+8 fits and the shifted result never overflows.
      dout_d      = v2_q ? WIDTH'((s_q + (WIDTH + 4)'(8)) >> 4) : '0;
      valid_out_d = v2_q;
      line_end_d  = v2_q && le2_q;
      frame_end_d = v2_q && fe2_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         top_q       <= '0;
         mid_q       <= '0;
         bot_q       <= '0;
         col_cnt_q   <= '0;
         row_cnt_q   <= '0;
         v1_q        <= 1'b0;
         le1_q       <= 1'b0;
         fe1_q       <= 1'b0;
         s_q         <= '0;
         v2_q        <= 1'b0;
         le2_q       <= 1'b0;
         fe2_q       <= 1'b0;
         dout_q      <= '0;
         valid_out_q <= 1'b0;
         line_end_q  <= 1'b0;
         frame_end_q <= 1'b0;
      end else begin
         top_q       <= top_d;
         mid_q       <= mid_d;
         bot_q       <= bot_d;
         col_cnt_q   <= col_cnt_d;
         row_cnt_q   <= row_cnt_d;
         v1_q        <= v1_d;
         le1_q       <= le1_d;
         fe1_q       <= fe1_d;
         s_q         <= s_d;
         v2_q        <= v2_d;
         le2_q       <= le2_d;
         fe2_q       <= fe2_d;
         dout_q      <= dout_d;
         valid_out_q <= valid_out_d;
         line_end_q  <= line_end_d;
         frame_end_q <= frame_end_d;
      end
   end

   assign dout      = dout_q;
   assign valid_out = valid_out_q;
   assign line_end  = line_end_q;
   assign frame_end = frame_end_q;

endmodule

// File: tb/tb_gauss3x3_window.sv
// Bench for gauss3x3_window: whole images are convolved by a reference model and the
// expected pixels are queued as taps are issued; a negedge monitor checks every output.
module tb_gauss3x3_window;

   localparam int WIDTH = 8;
   localparam int IW    = 6;
   localparam int IH    = 5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [WIDTH-1:0] tap_top, tap_mid, tap_bot, dout;
   logic taps_valid, valid_out, line_end, frame_end;

   gauss3x3_window #(.WIDTH(WIDTH), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)) dut (
      .clk(clk), .rst(rst),
      .tap_top(tap_top), .tap_mid(tap_mid), .tap_bot(tap_bot),
      .taps_valid(taps_valid),
      .dout(dout), .valid_out(valid_out), .line_end(line_end), .frame_end(frame_end)
   );

   // ---------------- scoreboard ----------------
   logic [WIDTH+1:0] exp_q[$];   // {frame_end, line_end, dout}
   int due_q[$];                 // cycle in which the output must appear
   int checks = 0;
   int errors = 0;
   int le_cnt = 0;
   int fe_cnt = 0;
   int img[IH][IW];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Gaussian of the 3x3 neighbourhood centred on image pixel (cy, cx).
   function automatic int ref_pix(input int cy, input int cx);
      int s = 0;
      for (int i = -1; i <= 1; i++)
         for (int j = -1; j <= 1; j++)
            s += img[cy+i][cx+j] * (i == 0 ? 2 : 1) * (j == 0 ? 2 : 1);
      return (s + 8) / 16;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [WIDTH+1:0] e;
      int d;
      if (valid_out) begin
         if (line_end) le_cnt++;
         if (frame_end) fe_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            e = exp_q.pop_front();
            d = due_q.pop_front();
            check("dout", int'(dout), int'(e[WIDTH-1:0]));
            check("line_end", int'(line_end), int'(e[WIDTH]));
            check("frame_end", int'(frame_end), int'(e[WIDTH+1]));
            check("latency", cyc, d);
         end
      end else begin
         check("idle_zero", int'({dout, line_end, frame_end}), 0);
      end
   end

   // ---------------- drivers ----------------
   task automatic idle_cycle();
      @(posedge clk); #1;
      taps_valid = 1'b0;
      tap_top = WIDTH'($urandom_range(0, 255));
      tap_mid = WIDTH'($urandom_range(0, 255));
      tap_bot = WIDTH'($urandom_range(0, 255));
   endtask

   // gap_mode: 0 none, 1 one idle between taps, 2 random gaps. limit < 0 drives the whole frame.
   task automatic drive_frame(input int gap_mode, input int limit);
      int n = 0;
      for (int y = 2; y < IH; y++) begin
         for (int x = 0; x < IW; x++) begin
            if (limit >= 0 && n >= limit) return;
            if (gap_mode == 1 && n > 0) idle_cycle();
            if (gap_mode == 2) repeat ($urandom_range(0, 2)) idle_cycle();
            @(posedge clk); #1;
            taps_valid = 1'b1;
            tap_top = WIDTH'(img[y-2][x]);
            tap_mid = WIDTH'(img[y-1][x]);
            tap_bot = WIDTH'(img[y][x]);
            if (x >= 2) begin
               exp_q.push_back({(x == IW-1 && y == IH-1), (x == IW-1), WIDTH'(ref_pix(y-1, x-1))});
               due_q.push_back(cyc + 3);
            end
            n++;
         end
      end
   endtask

   task automatic end_frame();
      idle_cycle();
   endtask

   // Reset with junk taps_valid held high; anything in flight is dropped.
   task automatic do_reset(input int ncyc);
      @(posedge clk); #1;
      rst = 1'b1;
      taps_valid = 1'b1;
      tap_top = WIDTH'($urandom_range(0, 255));
      @(posedge clk); #1;
      exp_q.delete();
      due_q.delete();
      repeat (ncyc - 1) begin
         @(posedge clk); #1;
         tap_mid = WIDTH'($urandom_range(0, 255));
      end
      rst = 1'b0;
      taps_valid = 1'b0;
   endtask

   task automatic fill_const(input int v);
      for (int y = 0; y < IH; y++)
         for (int x = 0; x < IW; x++)
            img[y][x] = v;
   endtask

   task automatic fill_rand();
      for (int y = 0; y < IH; y++)
         for (int x = 0; x < IW; x++)
            img[y][x] = $urandom_range(0, 255);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int le0, fe0, wait_cnt;
      taps_valid = 1'b1;
      tap_top = 8'd55; tap_mid = 8'd66; tap_bot = 8'd77;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valid_out", int'(valid_out), 0);
      check("reset_dout", int'(dout), 0);
      check("reset_line_end", int'(line_end), 0);
      check("reset_frame_end", int'(frame_end), 0);
      #1;
      rst = 1'b0;
      taps_valid = 1'b0;

      fill_const(100); drive_frame(0, -1); end_frame();
      fill_const(0); img[2][2] = 16; drive_frame(0, -1); end_frame();
      fill_const(0); img[0][0] = 8; drive_frame(0, -1); end_frame();
      fill_const(0); img[0][0] = 7; drive_frame(0, -1); end_frame();
      fill_const(255); drive_frame(0, -1); end_frame();

      fill_rand(); drive_frame(0, -1); end_frame();
      drive_frame(1, -1); end_frame();
      fill_rand(); drive_frame(2, -1); end_frame();

      repeat (5) idle_cycle();
      le0 = le_cnt; fe0 = fe_cnt;
      fill_rand(); drive_frame(0, -1);
      fill_rand(); drive_frame(0, -1); end_frame();
      repeat (5) idle_cycle();
      check("two_frame_line_ends", le_cnt - le0, 2 * (IH - 2));
      check("two_frame_frame_ends", fe_cnt - fe0, 2);

      fill_rand(); drive_frame(0, IW + 3);
      do_reset(3);
      fill_rand(); drive_frame(0, -1); end_frame();
      fill_rand(); drive_frame(2, -1); end_frame();

      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 20) begin
         @(posedge clk);
         wait_cnt++;
      end
      @(negedge clk);
      check("drain_pending", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
